instr_fetch_unit: RTL

//  Reader side of program ROM: fetches 16-bit instructions from the sync ROM that
//  the bench/loader writes, and hands them to pipeline decode with their PC.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: default geometry,
// instruction encodings the fetcher must recognise, and the fetch FSM states.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_A_BITS   = 10;
    localparam int unsigned IFU_I_BITS   = 16;
    localparam int unsigned IFU_DEPTH    = 2;
    localparam int unsigned IFU_RESET_PC = 0;

    localparam logic [IFU_I_BITS-1:0] IFU_NOP  = 16'h0000;
    localparam logic [IFU_I_BITS-1:0] IFU_HALT = 16'hF000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch queue: DEPTH entries of {instr, pc} with push/pop/flush.
// Flush wins over push/pop; a pop frees space for a push in the same cycle.
module instr_fetch_unit_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 26,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch side of the program ROM: owns the fetch PC, issues ROM reads into a
// small prefetch queue, handles jump redirects and stops for good on HALT.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned A_BITS   = IFU_A_BITS,
    parameter int unsigned I_BITS   = IFU_I_BITS,
    parameter int unsigned DEPTH    = IFU_DEPTH,
    parameter int unsigned RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              nrst,
    output logic              rom_rd_en,
    output logic [A_BITS-1:0] rom_addr,
    input  logic [I_BITS-1:0] rom_data,
    input  logic              redirect,
    input  logic [A_BITS-1:0] redirect_pc,
    input  logic              stall,
    output logic [I_BITS-1:0] instr,
    output logic [A_BITS-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    localparam int unsigned E_W   = I_BITS + A_BITS;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [I_BITS-1:0] HALT_W = I_BITS'(IFU_HALT);
    localparam logic [I_BITS-1:0] NOP_W  = I_BITS'(IFU_NOP);

    fetch_state_e      state_q, state_d;
    logic [A_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [A_BITS-1:0] ret_pc_q, ret_pc_d;
    logic              inflight_q, inflight_d;
    logic              hlt_seen_q, hlt_seen_d;
    logic              live_q, live_d;

    logic [E_W-1:0]    head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop, push, redir, halt_xfer, issue;
    logic [OCC_W-1:0]  occ;

    instr_fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .W     (E_W)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data ({rom_data, ret_pc_q}),
        .pop       (pop),
        .flush     (redir),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // live_q holds issue off for the first cycle after reset release
    always_comb begin
        live_d      = 1'b1;
        instr_valid = (state_q == ST_RUN) && !fifo_empty;
        instr       = fifo_empty ? NOP_W : head[A_BITS +: I_BITS];
        instr_pc    = fifo_empty ? '0 : head[0 +: A_BITS];
        halted      = (state_q == ST_HALT);

        pop       = instr_valid && !stall;
        halt_xfer = pop && (head[A_BITS +: I_BITS] == HALT_W);
        redir     = live_q && redirect && (state_q == ST_RUN) && !halt_xfer;
        // a redirect squashes the read returning this cycle
        push      = inflight_q && !redir && !hlt_seen_q;

        occ   = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue = live_q && (state_q == ST_RUN) && !halt_xfer &&
                (redir || (!hlt_seen_q && (occ < OCC_W'(DEPTH))));

        rom_rd_en  = issue;
        rom_addr   = redir ? redirect_pc : fetch_pc_q;
        fetch_pc_d = issue ? rom_addr + A_BITS'(1) : fetch_pc_q;
        ret_pc_d   = issue ? rom_addr : ret_pc_q;
        inflight_d = issue;

        hlt_seen_d = hlt_seen_q;
        if (redir) begin
            hlt_seen_d = 1'b0;
        end else if (push && (rom_data == HALT_W)) begin
            hlt_seen_d = 1'b1;
        end

        state_d = state_q;
        if ((state_q == ST_RUN) && halt_xfer) state_d = ST_HALT;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= A_BITS'(RESET_PC);
            ret_pc_q   <= '0;
            inflight_q <= 1'b0;
            hlt_seen_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
            hlt_seen_q <= hlt_seen_d;
            live_q     <= live_d;
        end
    end

endmodule
